// File: rtl/dsp48e2_alu_if.sv
// dsp48e2_alu_if: operand/control/result bundle for the DSP48E2 stand-in slice.
//   master : drives ce, a, b, c, carryin, alumode, opmode; receives p, carryout
//   slave  : the slice itself (receives operands, drives p, carryout)
interface dsp48e2_alu_if;
  logic        ce;
  logic [29:0] a;
  logic [17:0] b;
  logic [47:0] c;
  logic        carryin;
  logic [3:0]  alumode;
  logic [8:0]  opmode;
  logic [47:0] p;
  logic        carryout;

  modport master (
    output ce, a, b, c, carryin, alumode, opmode,
    input  p, carryout
  );

  modport slave (
    input  ce, a, b, c, carryin, alumode, opmode,
    output p, carryout
  );
endinterface

// File: rtl/dsp48e2_alu.sv
// dsp48e2_alu: behavioural DSP48E2 subset -- A:B concat, signed 27x18 multiply,
// C input, P feedback and the 48-bit ALU behind the X/Y/Z/W operand muxes.
// Ports:
//   clock    : clock
//   reset    : synchronous active-high reset of every enabled register
//   bus      : dsp48e2_alu_if.slave (ce, a, b, c, carryin, alumode, opmode -> p, carryout)
// Optional A/B/C/M/P register stages are selected by the *REG parameters;
// control inputs (alumode, opmode, carryin) always act combinationally.
module dsp48e2_alu #(
  parameter int unsigned AREG     = 0,
  parameter int unsigned BREG     = 0,
  parameter int unsigned CREG     = 0,
  parameter int unsigned MREG     = 0,
  parameter int unsigned PREG     = 0,
  parameter string       USE_MULT = "NONE",
  parameter logic [47:0] RND      = 48'h0
) (
  input logic          clock,
  input logic          reset,
  dsp48e2_alu_if.slave bus
);

  localparam int unsigned LP_AW  = 30;
  localparam int unsigned LP_BW  = 18;
  localparam int unsigned LP_PW  = 48;
  localparam int unsigned LP_MAW = 27;
  localparam int unsigned LP_MW  = 45;
  localparam int unsigned LP_SHR = 17;
  localparam bit          LP_USE_MULT = (USE_MULT == "MULTIPLY");

  logic [LP_AW-1:0]        w_a;
  logic [LP_BW-1:0]        w_b;
  logic [LP_PW-1:0]        w_c;
  logic [LP_PW-1:0]        w_ab;
  logic signed [LP_MW-1:0] w_prod;
  logic [LP_PW-1:0]        w_m_comb;
  logic [LP_PW-1:0]        w_m;
  logic [LP_PW-1:0]        w_pfb;
  logic [LP_PW-1:0]        w_x;
  logic [LP_PW-1:0]        w_y;
  logic [LP_PW-1:0]        w_z;
  logic [LP_PW-1:0]        w_w;
  logic [LP_PW-1:0]        w_s;
  logic [LP_PW:0]          w_sum;
  logic [LP_PW-1:0]        w_alu;
  logic                    w_co;

  // A input stage
  generate
    if (AREG == 1) begin : g_areg
      logic [LP_AW-1:0] r_a;
      always_ff @(posedge clock) begin
        if (reset)       r_a <= '0;
        else if (bus.ce) r_a <= bus.a;
      end
      assign w_a = r_a;
    end else begin : g_awire
      assign w_a = bus.a;
    end
  endgenerate

  // B input stage
  generate
    if (BREG == 1) begin : g_breg
      logic [LP_BW-1:0] r_b;
      always_ff @(posedge clock) begin
        if (reset)       r_b <= '0;
        else if (bus.ce) r_b <= bus.b;
      end
      assign w_b = r_b;
    end else begin : g_bwire
      assign w_b = bus.b;
    end
  endgenerate

  // C input stage
  generate
    if (CREG == 1) begin : g_creg
      logic [LP_PW-1:0] r_c;
      always_ff @(posedge clock) begin
        if (reset)       r_c <= '0;
        else if (bus.ce) r_c <= bus.c;
      end
      assign w_c = r_c;
    end else begin : g_cwire
      assign w_c = bus.c;
    end
  endgenerate

  assign w_ab = {w_a, w_b};

  // Signed 27x18 product, sign-extended to the 48-bit datapath
  assign w_prod   = LP_MW'($signed(w_a[LP_MAW-1:0])) * LP_MW'($signed(w_b));
  assign w_m_comb = LP_USE_MULT ? {{(LP_PW - LP_MW){w_prod[LP_MW-1]}}, w_prod} : '0;

  // Optional register after the multiplier
  generate
    if (MREG == 1) begin : g_mreg
      logic [LP_PW-1:0] r_m;
      always_ff @(posedge clock) begin
        if (reset)       r_m <= '0;
        else if (bus.ce) r_m <= w_m_comb;
      end
      assign w_m = r_m;
    end else begin : g_mwire
      assign w_m = w_m_comb;
    end
  endgenerate

  // Operand muxes; P feedback is zero when P is unregistered, so no loop exists
  always_comb begin
    w_x = '0;
    w_y = '0;
    w_z = '0;
    w_w = '0;

    case (bus.opmode[1:0])
      2'b01:   w_x = w_m;
      2'b10:   w_x = w_pfb;
      2'b11:   w_x = w_ab;
      default: w_x = '0;
    endcase

    // Y=01 is the second partial-product term, already folded into X
    case (bus.opmode[3:2])
      2'b10:   w_y = '1;
      2'b11:   w_y = w_c;
      default: w_y = '0;
    endcase

    case (bus.opmode[6:4])
      3'b010:  w_z = w_pfb;
      3'b011:  w_z = w_c;
      3'b100:  w_z = w_pfb;
      3'b110:  w_z = {{LP_SHR{w_pfb[LP_PW-1]}}, w_pfb[LP_PW-1:LP_SHR]};
      default: w_z = '0;
    endcase

    case (bus.opmode[8:7])
      2'b01:   w_w = w_pfb;
      2'b10:   w_w = RND;
      2'b11:   w_w = w_c;
      default: w_w = '0;
    endcase
  end

  assign w_s   = w_w + w_x + w_y + LP_PW'(bus.carryin);
  assign w_sum = {1'b0, w_z} + {1'b0, w_s};

  // ALU function select; carry is only meaningful for the plain add
  always_comb begin
    w_alu = '0;
    w_co  = 1'b0;
    case (bus.alumode)
      4'b0000: begin
        w_alu = w_sum[LP_PW-1:0];
        w_co  = w_sum[LP_PW];
      end
      4'b0011: w_alu = w_z - w_s;
      4'b0001: w_alu = ~w_z + w_s;   // -Z-1 is ~Z in two's complement
      4'b0010: w_alu = ~w_sum[LP_PW-1:0];
      4'b0100: w_alu = w_x ^ w_z;
      4'b1100: w_alu = w_x & w_z;
      4'b1110: w_alu = w_x | w_z;
      default: w_alu = '0;
    endcase
  end

  // Output stage and P feedback source
  generate
    if (PREG == 1) begin : g_preg
      logic [LP_PW-1:0] r_p;
      logic             r_co;
      always_ff @(posedge clock) begin
        if (reset) begin
          r_p  <= '0;
          r_co <= 1'b0;
        end else if (bus.ce) begin
          r_p  <= w_alu;
          r_co <= w_co;
        end
      end
      assign w_pfb        = r_p;
      assign bus.p        = r_p;
      assign bus.carryout = r_co;
    end else begin : g_pwire
      assign w_pfb        = '0;
      assign bus.p        = w_alu;
      assign bus.carryout = w_co;
    end
  endgenerate

endmodule

// File: tb/tb_dsp48e2_alu.sv
// tb_dsp48e2_alu: three slice configurations share one stimulus stream
//   u0 : fully combinational, multiplier on, non-zero RND
//   u1 : P register only, multiplier off
//   u2 : A/B/C/M/P registers, multiplier on
// A reference model predicts every output each cycle; literal checks pin the model.
module tb_dsp48e2_alu;

  localparam logic [47:0] RND0 = 48'h1234_5678_9ABC;
  localparam logic [47:0] RND1 = 48'h0;
  localparam logic [47:0] RND2 = 48'h0000_0000_0100;
  localparam longint MASK = 64'h0000_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        t_reset;
  logic        t_ce;
  logic [29:0] t_a;
  logic [17:0] t_b;
  logic [47:0] t_c;
  logic        t_cin;
  logic [3:0]  t_alu;
  logic [8:0]  t_op;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dsp48e2_alu_if if0 ();
  dsp48e2_alu_if if1 ();
  dsp48e2_alu_if if2 ();

  assign if0.ce = t_ce; assign if0.a = t_a; assign if0.b = t_b; assign if0.c = t_c;
  assign if0.carryin = t_cin; assign if0.alumode = t_alu; assign if0.opmode = t_op;
  assign if1.ce = t_ce; assign if1.a = t_a; assign if1.b = t_b; assign if1.c = t_c;
  assign if1.carryin = t_cin; assign if1.alumode = t_alu; assign if1.opmode = t_op;
  assign if2.ce = t_ce; assign if2.a = t_a; assign if2.b = t_b; assign if2.c = t_c;
  assign if2.carryin = t_cin; assign if2.alumode = t_alu; assign if2.opmode = t_op;

  dsp48e2_alu #(.USE_MULT("MULTIPLY"), .RND(RND0)) u0 (
    .clock(clk), .reset(t_reset), .bus(if0.slave));
  dsp48e2_alu #(.PREG(1), .USE_MULT("NONE"), .RND(RND1)) u1 (
    .clock(clk), .reset(t_reset), .bus(if1.slave));
  dsp48e2_alu #(.AREG(1), .BREG(1), .CREG(1), .MREG(1), .PREG(1),
                .USE_MULT("MULTIPLY"), .RND(RND2)) u2 (
    .clock(clk), .reset(t_reset), .bus(if2.slave));

  // Signed A[26:0] * signed B, as a 48-bit two's-complement value
  function automatic logic [47:0] prod(input logic [29:0] a, input logic [17:0] b);
    longint sa, sb;
    sa = $signed(a[26:0]);
    sb = $signed(b);
    return 48'(sa * sb);
  endfunction

  // Reference slice function: returns {carryout, p}
  function automatic logic [48:0] ref_alu(
      input logic [47:0] ab, input logic [47:0] m, input logic [47:0] c,
      input logic cin, input logic [3:0] alu, input logic [8:0] op,
      input logic [47:0] pfb, input logic [47:0] rnd);
    longint x, y, z, w, s, sp, t;
    x = 0; y = 0; z = 0; w = 0;
    case (op[1:0]) 2'd1: x = m; 2'd2: x = pfb; 2'd3: x = ab; default: x = 0; endcase
    case (op[3:2]) 2'd2: y = MASK; 2'd3: y = c; default: y = 0; endcase
    case (op[6:4])
      3'd2, 3'd4: z = pfb;
      3'd3: z = c;
      3'd6: begin sp = $signed(pfb); sp = sp >>> 17; z = sp & MASK; end
      default: z = 0;
    endcase
    case (op[8:7]) 2'd1: w = pfb; 2'd2: w = rnd; 2'd3: w = c; default: w = 0; endcase
    s = (w + x + y + longint'(cin)) & MASK;
    case (alu)
      4'b0000: begin t = z + s; return 49'(t); end
      4'b0011: return {1'b0, 48'(z - s)};
      4'b0001: return {1'b0, 48'(s - z - 1)};
      4'b0010: return {1'b0, 48'(~(z + s))};
      4'b0100: return {1'b0, 48'(x ^ z)};
      4'b1100: return {1'b0, 48'(x & z)};
      4'b1110: return {1'b0, 48'(x | z)};
      default: return 49'd0;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [48:0] got, input logic [48:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got p=%h co=%b, expected p=%h co=%b",
               name, got[47:0], got[48], exp[47:0], exp[48]);
    end
  endtask

  // Model state: u1 P value; u2 P value plus captured input history
  logic [48:0] m1, m2, r1, r2;
  logic [29:0] h0_a, h1_a;
  logic [17:0] h0_b, h1_b;
  logic [47:0] h0_c;

  always @(posedge clk) begin
    if (t_reset) begin
      m1 = '0; m2 = '0;
      h0_a = '0; h1_a = '0; h0_b = '0; h1_b = '0; h0_c = '0;
    end else if (t_ce) begin
      r1 = ref_alu({t_a, t_b}, 48'd0, t_c, t_cin, t_alu, t_op, m1[47:0], RND1);
      r2 = ref_alu({h0_a, h0_b}, prod(h1_a, h1_b), h0_c, t_cin, t_alu, t_op, m2[47:0], RND2);
      m1 = r1; m2 = r2;
      h1_a = h0_a; h1_b = h0_b;
      h0_a = t_a; h0_b = t_b; h0_c = t_c;
    end
  end

  // Per-cycle comparison of all three slices against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp($sformatf("u0_model@%0t", $time), {if0.carryout, if0.p},
          ref_alu({t_a, t_b}, prod(t_a, t_b), t_c, t_cin, t_alu, t_op, 48'd0, RND0));
      cmp($sformatf("u1_model@%0t", $time), {if1.carryout, if1.p}, m1);
      cmp($sformatf("u2_model@%0t", $time), {if2.carryout, if2.p}, m2);
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [8:0] op, input logic [3:0] alu, input logic cin,
                       input logic [29:0] a, input logic [17:0] b, input logic [47:0] c);
    t_op = op; t_alu = alu; t_cin = cin; t_a = a; t_b = b; t_c = c;
    edge1();
  endtask

  initial begin
    t_reset = 1'b1; t_ce = 1'b0; t_a = '0; t_b = '0; t_c = '0;
    t_cin = 1'b0; t_alu = 4'b0000; t_op = 9'd0;
    edge1();
    t_reset = 1'b0;
    chk_en  = 1'b1;
    cmp("u1_reset", {if1.carryout, if1.p}, 49'd0);
    cmp("u2_reset", {if2.carryout, if2.p}, 49'd0);

    // Combinational arithmetic on u0
    t_ce = 1'b1; t_op = 9'b000110011; t_alu = 4'b0000; t_c = 48'd5; t_a = '0; t_b = 18'd7;
    #1 cmp("add_5_7", {if0.carryout, if0.p}, {1'b0, 48'd12});
    t_c = 48'hFFFF_FFFF_FFFF; t_b = 18'd1;
    #1 cmp("add_carry", {if0.carryout, if0.p}, {1'b1, 48'd0});
    t_alu = 4'b0011; t_c = 48'd10; t_b = 18'd3;
    #1 cmp("sub_10_3", {if0.carryout, if0.p}, {1'b0, 48'd7});
    t_alu = 4'b0001;
    #1 cmp("negz_plus_s", {if0.carryout, if0.p}, {1'b0, 48'hFFFF_FFFF_FFF8});
    t_alu = 4'b0000; t_op = 9'b000000101; t_a = 30'h07FF_FFFD; t_b = 18'd4;
    #1 cmp("mult_m3x4", {if0.carryout, if0.p}, {1'b0, 48'hFFFF_FFFF_FFF4});

    // Logic modes on u0
    edge1();
    t_op = 9'b000110011; t_a = '0; t_b = 18'h0F0F0; t_c = 48'h0FF0; t_alu = 4'b0100;
    #1 cmp("xor", {if0.carryout, if0.p}, {1'b0, 48'hFF00});
    t_alu = 4'b1100;
    #1 cmp("and", {if0.carryout, if0.p}, {1'b0, 48'h00F0});
    t_alu = 4'b1110;
    #1 cmp("or", {if0.carryout, if0.p}, {1'b0, 48'hFFF0});

    // P accumulation on u1, ce hold, reset with ce low
    edge1();
    t_reset = 1'b1; t_ce = 1'b0;
    edge1();
    t_reset = 1'b0; t_ce = 1'b1;
    t_op = 9'b000100011; t_alu = 4'b0000; t_cin = 1'b0; t_a = '0; t_b = 18'd1; t_c = '0;
    edge1(); cmp("acc_1", {if1.carryout, if1.p}, {1'b0, 48'd1});
    edge1(); cmp("acc_2", {if1.carryout, if1.p}, {1'b0, 48'd2});
    edge1(); cmp("acc_3", {if1.carryout, if1.p}, {1'b0, 48'd3});
    t_ce = 1'b0;
    edge1(); edge1(); cmp("acc_hold", {if1.carryout, if1.p}, {1'b0, 48'd3});
    t_reset = 1'b1;
    edge1(); cmp("acc_reset", {if1.carryout, if1.p}, 49'd0);
    t_reset = 1'b0;

    // Pipeline latency on u2
    t_reset = 1'b1;
    edge1();
    t_reset = 1'b0; t_ce = 1'b1; t_op = 9'b000110011; t_alu = 4'b0000;
    t_a = '0; t_b = '0; t_c = '0;
    edge1();
    t_b = 18'd7; t_c = 48'd5;
    edge1(); cmp("pipe_n1", {if2.carryout, if2.p}, 49'd0);
    edge1(); cmp("pipe_n2", {if2.carryout, if2.p}, {1'b0, 48'd12});
    t_ce = 1'b0; t_c = 48'd100;
    edge1(); edge1(); cmp("pipe_ce0", {if2.carryout, if2.p}, {1'b0, 48'd12});
    t_ce = 1'b1;
    edge1(); edge1(); cmp("pipe_resume", {if2.carryout, if2.p}, {1'b0, 48'd107});
    t_op = 9'b000000101; t_a = 30'h07FF_FFFD; t_b = 18'd4;
    edge1(); edge1(); edge1();
    cmp("pipe_mult", {if2.carryout, if2.p}, {1'b0, 48'hFFFF_FFFF_FFF4});

    // Directed vectors covering remaining mux codes and ALU modes (model-checked)
    t_reset = 1'b1;
    edge1();
    t_reset = 1'b0;
    apply(9'b000110011, 4'b0000, 1'b1, 30'd0, 18'd1, 48'h8000_0000_0000);
    cmp("u1_big", {if1.carryout, if1.p}, {1'b0, 48'h8000_0000_0002});
    apply(9'b001100011, 4'b0000, 1'b0, 30'd0, 18'd5, 48'd0);
    apply(9'b011000000, 4'b0000, 1'b0, 30'd0, 18'd0, 48'd0);
    apply(9'b100001010, 4'b0000, 1'b1, 30'd0, 18'd0, 48'd0);
    apply(9'b110111111, 4'b0011, 1'b0, 30'h2AAA_AAAA, 18'h15555, 48'h0123_4567_89AB);
    apply(9'b000110011, 4'b0001, 1'b1, 30'h3FFF_FFFF, 18'h3FFFF, 48'h7);
    apply(9'b000110011, 4'b0010, 1'b0, 30'h0000_1234, 18'h00ABC, 48'h1111);
    apply(9'b000110011, 4'b0101, 1'b0, 30'h0000_0001, 18'h00001, 48'h2222);
    apply(9'b000100010, 4'b1100, 1'b0, 30'h0, 18'h0, 48'h0);
    apply(9'b001010101, 4'b0000, 1'b0, 30'h0400_0000, 18'h20000, 48'h5);
    apply(9'b001110011, 4'b0000, 1'b1, 30'h0000_00FF, 18'h000FF, 48'h9);
    apply(9'b011110111, 4'b0000, 1'b0, 30'h3FFF_FFFF, 18'h3FFFF, 48'hFFFF_FFFF_FFFF);
    apply(9'b000000000, 4'b1111, 1'b1, 30'h1, 18'h1, 48'h1);
    edge1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
